// File: rtl/cordic_arbiter.sv
// Round-robin arbiter/sequencer sharing one cordic_top between NREQ requesters.
// Optional WAIT abort counter is built only when CORDIC_ARB_TIMEOUT_EN is defined.
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   angle_flat,
    output logic [NREQ-1:0]      gnt,
    output logic                 core_valid_in,
    output logic [31:0]          core_angle,
    input  logic [15:0]          core_cos,
    input  logic [15:0]          core_sin,
    input  logic [2:0]           core_flip,
    input  logic                 core_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_cos,
    output logic [15:0]          rsp_sin,
    output logic [2:0]           rsp_flip,
    output logic                 rsp_timeout,
    output logic                 busy
);

    if (NREQ < 2 || NREQ > 16 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_bad_cfg
        $error("cordic_arbiter: illegal NREQ/IDW/TIMEOUT combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state;
    logic [IDW-1:0]  last;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  cand;
    logic [31:0]     pick_angle;

    // Scan upward from last+1 with wrap; the first set request wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IDW'((32'(last) + off) % NREQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_angle = angle_flat[32*int'(pick_idx) +: 32];
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            last          <= IDW'(NREQ - 1);
            gnt           <= '0;
            core_valid_in <= 1'b0;
            core_angle    <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_cos       <= '0;
            rsp_sin       <= '0;
            rsp_flip      <= '0;
            busy          <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            gnt           <= '0;
            core_valid_in <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        gnt        <= NREQ'(1) << pick_idx;
                        core_angle <= pick_angle;
                        rsp_id     <= pick_idx;
                        last       <= pick_idx;
                        busy       <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    core_valid_in <= 1'b1;
                    state         <= ST_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                end
                ST_WAIT: begin
                    // A result on the expiry cycle still takes priority over the abort.
                    if (core_valid) begin
                        rsp_cos   <= core_cos;
                        rsp_sin   <= core_sin;
                        rsp_flip  <= core_flip;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        timeout_q <= 1'b0;
                    end else if (wait_cnt == CW'(TIMEOUT)) begin
                        rsp_cos   <= '0;
                        rsp_sin   <= '0;
                        rsp_flip  <= '0;
                        rsp_valid <= 1'b1;
                        timeout_q <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed self-checking bench for cordic_arbiter; the bench plays the cordic core.
// Timeout scenario runs only when CORDIC_ARB_TIMEOUT_EN is defined.
module tb_cordic_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] angle_flat;
    logic [3:0]   gnt;
    logic         core_valid_in;
    logic [31:0]  core_angle;
    logic [15:0]  core_cos = '0;
    logic [15:0]  core_sin = '0;
    logic [2:0]   core_flip = '0;
    logic         core_valid = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [15:0]  rsp_cos;
    logic [15:0]  rsp_sin;
    logic [2:0]   rsp_flip;
    logic         rsp_timeout;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    cordic_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .angle_flat(angle_flat), .gnt(gnt),
        .core_valid_in(core_valid_in), .core_angle(core_angle),
        .core_cos(core_cos), .core_sin(core_sin), .core_flip(core_flip),
        .core_valid(core_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_flip(rsp_flip),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for a grant, plays the core with latency lat, optionally stalls the response.
    task automatic txn(input logic [3:0] egnt, input logic [31:0] eang, input int lat,
                       input logic [15:0] c, input logic [15:0] s, input logic [2:0] f,
                       input int stall, input bit drop);
        int k;
        logic [1:0] eid;
        k = 0;
        while (gnt == '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("gnt", gnt, egnt);
        check("busy_gnt", busy, 1);
        eid = '0;
        for (int i = 0; i < 4; i++) if (egnt[i]) eid = 2'(i);
        if (drop) req = req & ~egnt;
        @(negedge clk);
        check("issue", {gnt, core_valid_in}, {4'b0, 1'b1});
        check("angle", core_angle, eang);
        repeat (lat - 1) @(negedge clk);
        check("no_rsp_early", {rsp_valid, busy}, {1'b0, 1'b1});
        core_cos = c; core_sin = s; core_flip = f; core_valid = 1'b1;
        @(negedge clk);
        core_valid = 1'b0; core_cos = '0; core_sin = '0; core_flip = '0;
        check("rsp", {rsp_valid, rsp_id, rsp_cos, rsp_sin, rsp_flip, rsp_timeout},
              {1'b1, eid, c, s, f, 1'b0});
        for (int i = 0; i < stall; i++) begin
            core_valid = (i == 5);
            core_cos   = ~c;
            core_sin   = ~s;
            @(negedge clk);
            check("bp_hold", {rsp_valid, busy, gnt, rsp_id, rsp_cos, rsp_sin, rsp_flip},
                  {1'b1, 1'b1, 4'b0, eid, c, s, f});
        end
        core_valid = 1'b0; core_cos = '0; core_sin = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", {rsp_valid, busy, gnt}, {1'b0, 1'b0, 4'b0});
    endtask

    initial begin
        angle_flat = {32'hBF800000, 32'h40400000, 32'h40000000, 32'h3F800000};

        repeat (2) @(negedge clk);
        check("reset_outs", {gnt, core_valid_in, core_angle, rsp_valid, rsp_id, rsp_cos,
                             rsp_sin, rsp_flip, rsp_timeout, busy}, '0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_quiet", {gnt, busy, core_valid_in}, '0);

        // Contention with all requests held: 0,1,2,3,0.
        req = 4'b1111;
        txn(4'b0001, 32'h3F800000, 3, 16'h1111, 16'h2222, 3'd1, 0, 1'b0);
        txn(4'b0010, 32'h40000000, 4, 16'h3333, 16'h4444, 3'd2, 0, 1'b0);
        txn(4'b0100, 32'h40400000, 2, 16'h5555, 16'h6666, 3'd3, 0, 1'b0);
        txn(4'b1000, 32'hBF800000, 5, 16'h7777, 16'h8888, 3'd4, 0, 1'b0);
        txn(4'b0001, 32'h3F800000, 1, 16'h9999, 16'hAAAA, 3'd5, 0, 1'b0);
        req = 4'b0000;

        // Single request, core latency 10.
        @(negedge clk);
        req = 4'b0001;
        txn(4'b0001, 32'h3F800000, 10, 16'h3C52, 16'h3AB8, 3'd0, 0, 1'b1);

        // Back-pressure: 20 stalled cycles with a spurious done in RESP, second request pending.
        req = 4'b0110;
        txn(4'b0010, 32'h40000000, 6, 16'h1234, 16'h5678, 3'd6, 20, 1'b1);
        @(negedge clk);
        check("gnt_after_bp", gnt, 4'b0100);
        txn(4'b0100, 32'h40400000, 2, 16'hCAFE, 16'hBEEF, 3'd7, 0, 1'b1);

        // Spurious done while idle.
        core_cos = 16'hDEAD; core_valid = 1'b1;
        @(negedge clk);
        core_valid = 1'b0; core_cos = '0;
        @(negedge clk);
        check("spurious_idle", {busy, rsp_valid, gnt, core_valid_in, rsp_cos},
              {1'b0, 1'b0, 4'b0, 1'b0, 16'hCAFE});

`ifdef CORDIC_ARB_TIMEOUT_EN
        begin
            int k;
            req = 4'b1000;
            k = 0;
            while (gnt == '0 && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("to_gnt", gnt, 4'b1000);
            req = 4'b0000;
            @(negedge clk);
            check("to_issue", core_valid_in, 1);
            for (int j = 1; j <= 8; j++) begin
                @(negedge clk);
                check("to_wait", rsp_valid, 0);
            end
            @(negedge clk);
            check("to_rsp", {rsp_valid, rsp_timeout, rsp_id, rsp_cos, rsp_sin, rsp_flip},
                  {1'b1, 1'b1, 2'd3, 16'h0, 16'h0, 3'd0});
            core_cos = 16'h7FFF; core_valid = 1'b1;
            @(negedge clk);
            core_valid = 1'b0; core_cos = '0;
            check("to_late", {rsp_valid, rsp_timeout, rsp_cos}, {1'b1, 1'b1, 16'h0});
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("to_done", {rsp_valid, busy}, '0);
        end
`endif

        // Reset during WAIT, then requester 0 wins first again.
        req = 4'b0010;
        begin
            int k;
            k = 0;
            while (gnt == '0 && k < 40) begin
                @(negedge clk);
                k++;
            end
        end
        check("rw_gnt", gnt, 4'b0010);
        req = 4'b0000;
        @(negedge clk);
        check("rw_issue", core_valid_in, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rw_reset", {gnt, core_valid_in, core_angle, rsp_valid, rsp_id, rsp_cos,
                           rsp_sin, rsp_flip, rsp_timeout, busy}, '0);
        @(negedge clk);
        rst = 1'b1;
        core_cos = 16'h4321; core_valid = 1'b1;
        @(negedge clk);
        core_valid = 1'b0; core_cos = '0;
        @(negedge clk);
        check("rw_late_done", {rsp_valid, busy, rsp_cos}, '0);
        req = 4'b1111;
        txn(4'b0001, 32'h3F800000, 3, 16'h0F0F, 16'hF0F0, 3'd2, 0, 1'b1);
        req = 4'b0000;

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin arbiter and sequencer sharing one `cordic_top` instance between `NREQ` requesters. It grants one request at a time and drives the core's `valid_in`/angle. It then waits for the core's `valid`, captures `cos`/`sin`/`flip`, and returns them on a `valid`/`ready` response channel tagged with the requester index. The block sits between the requester-side logic and `cordic_top`. Exactly one transaction is in flight at any time.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, 2: requester-index width; must equal `$clog2(NREQ)`.
- `TIMEOUT`, 64: maximum WAIT cycles before abort. Used only with `CORDIC_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  per-requester request level; held until granted.
- `angle_flat`  in  `NREQ*32`  IEEE-754 angles; requester i occupies bits `[32i+31:32i]`.
- `gnt`  out  `NREQ`  one-hot, one-cycle accept pulse.
- `core_valid_in`  out  1  start strobe to `cordic_top`.
- `core_angle`  out  32  angle to `cordic_top`.
- `core_cos`, `core_sin`  in  16 each  core results.
- `core_flip`  in  3  core quadrant flag.
- `core_valid`  in  1  core done strobe.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  `IDW`  index of the granted requester.
- `rsp_cos`, `rsp_sin`  out  16 each  captured results.
- `rsp_flip`  out  3  captured flip.
- `rsp_timeout`  out  1  response is an abort (timeout build only; otherwise tied to 0).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `req` is non-zero, select the first set bit scanning upward, with wrap, from `last+1`.
  - Pulse `gnt` for that bit.
  - Latch its angle and index; set `last` to the index.
  - Go to ISSUE.
- ISSUE:
  - `core_valid_in`=1 for exactly one cycle; `core_angle` = latched angle.
  - Go to WAIT.
- WAIT:
  - On `core_valid`=1, capture `core_cos`/`core_sin`/`core_flip` into the response registers and go to RESP.
- RESP:
  - `rsp_valid`=1. Data, `rsp_id` and `rsp_timeout` stay stable until `rsp_valid && rsp_ready`.
  - On that handshake, go to IDLE.
- `core_valid` outside WAIT is ignored; no state or data change.
- `req` changes outside IDLE are ignored. Arbitration is evaluated only in IDLE.
- `core_angle` holds the last latched value in all states. The core samples it only with `core_valid_in`.

## Timing
- Reset values: `gnt`=0, `core_valid_in`=0, `core_angle`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_cos`=0, `rsp_sin`=0, `rsp_flip`=0, `rsp_timeout`=0, `busy`=0, state=IDLE.
- The `last` pointer resets to `NREQ-1`, so requester 0 has first priority after reset.
- Cycle 0 (IDLE, request seen): `gnt` pulse. Cycle 1: `core_valid_in`. `rsp_valid` rises the cycle after `core_valid` is sampled in WAIT.
- Minimum request-to-request spacing: the RESP handshake cycle + 1 IDLE cycle + 1 ISSUE cycle + core latency + 1.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. A core result arriving after reset release is ignored, because the FSM is not in WAIT.

## Configuration
- Macro: `CORDIC_ARB_TIMEOUT_EN`.
- Defined:
  - A WAIT-cycle counter is cleared on entry to WAIT.
  - If it reaches `TIMEOUT` without `core_valid`, go to RESP with `rsp_timeout`=1 and `rsp_cos`=`rsp_sin`=`rsp_flip`=0.
  - If `core_valid` arrives on the expiry cycle, the normal result wins.
- Undefined: no counter is built, WAIT waits indefinitely, and `rsp_timeout` is constant 0.

## Test plan
- Single request: `req`=0001 with angle 0x3F800000, core returns cos=0x3C52 and sin=0x3AB8 after 10 cycles -> `gnt`=0001 for 1 cycle, `core_valid_in` the next cycle, then `rsp_valid` with `rsp_id`=0, cos=0x3C52, sin=0x3AB8.
- Contention: `req`=1111 held -> grant order 0,1,2,3,0. Each requester's angle is forwarded on `core_angle`.
- Back-pressure: `rsp_ready`=0 for 20 cycles -> `rsp_*` stable, `busy`=1, no new `gnt`. After `rsp_ready`=1, the next `gnt` is at least 2 cycles later.
- Spurious done: `core_valid` pulsed in IDLE and in RESP -> no state change, response unchanged.
- Timeout build, `TIMEOUT`=8, core silent -> `rsp_valid` 9 cycles after `core_valid_in`, with `rsp_timeout`=1 and zero data. A late `core_valid` is ignored.
- Reset in WAIT: `rst` low 2 cycles -> all outputs 0. The next request after release is granted to requester 0 first.
